// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with per-digit blank guard time.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 16,
  parameter int GUARD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;

  // One divider serves both SHOW and GUARD intervals.
  localparam int DW = ($clog2(REFRESH_DIV) > 8) ? $clog2(REFRESH_DIV) : 8;
  localparam logic [DW-1:0] SHOW_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GUARD_LAST = DW'(GUARD_CYC - 1);

  logic [1:0]      state, state_nxt;
  logic [DW-1:0]   div, div_nxt;
  logic [2:0]      sel_nxt;
  logic            blank_nxt, fd_nxt, lz_blank;
  logic [7:0][3:0] digit;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [7:0] lz;

  // lz[i]: digits i..7 are all zero; digit 0 is never suppressed.
  always_comb begin
    lz    = '0;
    lz[7] = (digit[7] == 4'd0);
    for (int i = 6; i >= 1; i--)
      lz[i] = lz[i+1] && (digit[i] == 4'd0);
  end

  assign lz_blank = lz[sel_nxt];
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    sel_nxt   = sel;
    fd_nxt    = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      div_nxt   = '0;
      sel_nxt   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          div_nxt   = '0;
          sel_nxt   = 3'd0;
        end
        SHOW: begin
          if (div == SHOW_LAST) begin
            state_nxt = GUARD;
            div_nxt   = '0;
          end else begin
            div_nxt = div + 1'b1;
          end
        end
        GUARD: begin
          if (div == GUARD_LAST) begin
            state_nxt = SHOW;
            div_nxt   = '0;
            sel_nxt   = sel + 3'd1;
            fd_nxt    = (sel == 3'd7);
          end else begin
            div_nxt = div + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          div_nxt   = '0;
          sel_nxt   = 3'd0;
        end
      endcase
    end
    blank_nxt = (state_nxt != SHOW) || lz_blank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      sel        <= 3'd0;
      num        <= 4'd0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      digit      <= '0;
    end else begin
      state      <= state_nxt;
      div        <= div_nxt;
      sel        <= sel_nxt;
      blank      <= blank_nxt;
      frame_done <= fd_nxt;
      // Pre-edge digit contents: a write shows up on num one cycle later.
      num        <= digit[sel_nxt];
      if (wr_en)
        digit[wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL expose parameter REFRESH_DIV, default 16, meaning clock cycles each digit is shown (legal range 2..2^20).
REQ-002 The block SHALL expose parameter GUARD_CYC, default 2, meaning blanked dead-time cycles between digits (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: scanning runs while high.
REQ-006 The block SHALL have port wr_en, input, 1 bit: digit-register write strobe.
REQ-007 The block SHALL have port wr_addr, input, 3 bits: digit index 0..7 to write.
REQ-008 The block SHALL have port wr_data, input, 4 bits: hex nibble to store.
REQ-009 The block SHALL have port num, output, 4 bits: nibble to the 7-segment decoder.
REQ-010 The block SHALL have port sel, output, 3 bits: digit index to the decoder's anode select.
REQ-011 The block SHALL have port blank, output, 1 bit: high means the downstream drives all anodes off.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on each completed 8-digit frame.

Function
REQ-013 The block SHALL hold eight 4-bit digit registers; when wr_en is high, wr_data is written to digit[wr_addr] at the clock edge.
REQ-014 All outputs SHALL be registered; num SHALL equal digit[sel] as of the previous edge, so a write to the shown digit appears on num 1 cycle later.
REQ-015 The FSM SHALL have three states: IDLE, SHOW, GUARD.
REQ-016 IDLE behaviour: blank=1, sel=0, divider=0; when enable=1 the FSM SHALL go to SHOW on the next edge.
REQ-017 SHOW behaviour: blank=0 for exactly REFRESH_DIV cycles, then the FSM SHALL go to GUARD and clear the divider.
REQ-018 GUARD behaviour: blank=1 for exactly GUARD_CYC cycles, then the FSM SHALL set sel to (sel+1) mod 8 and return to SHOW.
REQ-019 The digit period SHALL be REFRESH_DIV+GUARD_CYC cycles; the frame period SHALL be 8x that.
REQ-020 On the GUARD-to-SHOW transition where sel wraps 7 to 0, frame_done SHALL pulse high for exactly 1 cycle; frame_done SHALL be 0 at all other times.
REQ-021 If enable drops in any state, the FSM SHALL enter IDLE on the next edge, with sel=0, blank=1 and no frame_done pulse.
REQ-022 Re-enable SHALL always restart from digit 0 with a full SHOW interval.
REQ-023 Writes SHALL be accepted in every state, including IDLE and during reset deassertion cycle +1, and SHALL not disturb the scan timing.
REQ-024 A write and a sel advance on the same edge SHALL both take effect; num on the following cycle reflects the new sel and the already-written data.

Reset
REQ-025 When rst=1 at an edge, the block SHALL set state=IDLE, divider=0, sel=0, num=0, blank=1, frame_done=0, and all digit registers to 0.
REQ-026 rst SHALL take priority over wr_en and enable; rst asserted mid-SHOW or mid-GUARD SHALL abort the scan immediately with no frame_done.

Configuration
REQ-027 When macro SEG_SCAN_LZ_BLANK_EN is defined, blank SHALL also be high during SHOW for any digit i>0 where digit[7..i] are all zero (leading-zero suppression); digit 0 SHALL always be shown.
REQ-028 When SEG_SCAN_LZ_BLANK_EN is undefined, SHOW SHALL never blank, and no suppression logic SHALL exist.

Verification (REFRESH_DIV=4, GUARD_CYC=1)
REQ-029 Reset scenario: rst for 2 cycles -> num=0, sel=0, blank=1, frame_done=0; all digits read back 0 by scanning.
REQ-030 Scan-order scenario: write digit[i]=i+8 for i=0..7, then enable=1 -> sel steps 0..7, each shown 4 cycles, blank 1 cycle between digits, num=sel+8, frame_done pulses every 40 cycles.
REQ-031 Live-write scenario: while sel=3 is shown, write digit[3]=0xA -> num=0xA on the next cycle, and timing is unchanged.
REQ-032 Disable scenario: drop enable in mid-GUARD at sel=5 -> the next cycle is IDLE, sel=0, blank=1; re-enable gives sel=0 for a full 4 cycles.
REQ-033 Mid-scan reset scenario: assert rst at sel=7 one cycle before wrap -> no frame_done pulse, and all digits are cleared.
REQ-034 Leading-zero scenario: with the macro defined, digits = 0x00000305 (digit7..digit0) -> blank=1 during SHOW for sel=7..3 and blank=0 for sel=2..0; with the macro undefined, all eight digits are shown.
